// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle valid/frame_err pulses.
// Byte is presented HALF_PERIOD + 9*BIT_PERIOD clocks after the start edge is seen; no backpressure.
module uart_rx #(
   parameter int BAUD_RATE  = 9600,
   parameter int CLOCK_FREQ = 96000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int BIT_PERIOD  = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF_PERIOD = BIT_PERIOD / 2;
   localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t      state_q, state_d;
   logic [15:0] counter_q, counter_d;
   logic [2:0]  bit_index_q, bit_index_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        frame_err_q, frame_err_d;
   logic        busy_q, busy_d;
   logic        rx_s1_q, rx_s2_q;

   always_comb begin
      state_d     = state_q;
      counter_d   = counter_q;
      bit_index_d = bit_index_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s2_q) begin
               state_d   = START;
               counter_d = 16'd0;
            end
         end
         START: begin
            if (counter_q == HALF_LAST) begin
               counter_d = 16'd0;
               if (!rx_s2_q) begin
                  state_d     = DATA;
                  bit_index_d = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               counter_d = counter_q + 16'd1;
            end
         end
         DATA: begin
            if (counter_q == BIT_LAST) begin
               counter_d = 16'd0;
               shreg_d   = {rx_s2_q, shreg_q[7:1]};
               if (bit_index_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_index_d = bit_index_q + 3'd1;
               end
            end else begin
               counter_d = counter_q + 16'd1;
            end
         end
         STOP: begin
            if (counter_q == BIT_LAST) begin
               counter_d = 16'd0;
               if (rx_s2_q) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_HIGH;
               end
            end else begin
               counter_d = counter_q + 16'd1;
            end
         end
         // A held-low line must return high before another start can be seen.
         WAIT_HIGH: begin
            if (rx_s2_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         counter_q   <= 16'd0;
         bit_index_q <= 3'd0;
         shreg_q     <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         bit_index_q <= bit_index_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         rx_s1_q     <= rx;
         rx_s2_q     <= rx_s1_q;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule
